// File: rtl/dht11_meas_scheduler.sv
// rtl/dht11_meas_scheduler.sv - DHT11 measurement scheduler: request merge, holdoff, watchdog, retry
// Optional DHT_SCHED_STATS_EN adds saturating success/failure-attempt counters.
module dht11_meas_scheduler #(
    parameter int CLK_PER_US      = 100,
    parameter int MIN_INTERVAL_MS = 2000,
    parameter int AUTO_PERIOD_MS  = 5000,
    parameter int WAIT_TIMEOUT_MS = 30,
    parameter int MAX_RETRY       = 2
) (
    input  logic       iClk,
    input  logic       iRstn,
    input  logic       iReqBtn,
    input  logic       iReqUart,
    input  logic       iAutoEn,
    input  logic       iDhtBusy,
    input  logic       iDhtDone,
    input  logic       iDhtErr,
    output logic       oDhtStart,
    output logic       oBusy,
    output logic       oMeasDone,
    output logic       oMeasFail,
    output logic [1:0] oSrc,
    output logic [1:0] oRetryCnt
`ifdef DHT_SCHED_STATS_EN
    ,
    output logic [15:0] oOkCnt,
    output logic [15:0] oFailCnt
`endif
);

    localparam int TICK_CYC = CLK_PER_US * 1000;
    localparam int PW = $clog2(TICK_CYC + 1);
    localparam int HW = $clog2(MIN_INTERVAL_MS + 1);
    localparam int AW = $clog2(AUTO_PERIOD_MS + 1);
    localparam int WW = $clog2(WAIT_TIMEOUT_MS + 1);

    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYC - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(MIN_INTERVAL_MS);
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD_MS - 1);
    localparam logic [WW-1:0] WD_LAST   = WW'(WAIT_TIMEOUT_MS - 1);
    localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);

    typedef enum logic [1:0] {IDLE, START, WAIT, RETRY} state_e;

    state_e        state_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [AW-1:0] auto_q, auto_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          pend_btn_q, pend_btn_d, pend_uart_q, pend_uart_d, pend_auto_q, pend_auto_d;
    logic          start_q, busy_q, done_q, fail_q;
    logic [1:0]    src_q, retry_q;
    logic          tick, auto_fire, wd_expire, in_wait, ok_ev, fail_ev, launch;

    always_comb begin
        tick      = (presc_q == TICK_LAST);
        auto_fire = iAutoEn && tick && (auto_q == AUTO_LAST);
        wd_expire = tick && (wd_q == WD_LAST);
        in_wait   = (state_q == WAIT);
        // Error beats a simultaneous done; a done beats a simultaneous watchdog expiry.
        ok_ev     = in_wait && iDhtDone && !iDhtErr;
        fail_ev   = in_wait && (iDhtErr || (wd_expire && !iDhtDone));
        launch    = (state_q == IDLE) && (pend_btn_q || pend_uart_q || pend_auto_q)
                    && (hold_q == '0) && !iDhtBusy;

        pend_btn_d  = iReqBtn   || (pend_btn_q  && !launch);
        pend_uart_d = iReqUart  || (pend_uart_q && !launch);
        pend_auto_d = auto_fire || (pend_auto_q && !launch);

        presc_d = (state_q == START || tick) ? '0 : presc_q + 1'b1;

        hold_d = hold_q;
        if (ok_ev || fail_ev) begin
            hold_d = HOLD_LOAD;
        end else if (tick && hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end

        auto_d = auto_q;
        if (!iAutoEn || auto_fire) begin
            auto_d = '0;
        end else if (tick) begin
            auto_d = auto_q + 1'b1;
        end

        wd_d = wd_q;
        if (state_q == START) begin
            wd_d = '0;
        end else if (in_wait && tick && !wd_expire) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            presc_q     <= '0;
            hold_q      <= '0;
            auto_q      <= '0;
            wd_q        <= '0;
            pend_btn_q  <= 1'b0;
            pend_uart_q <= 1'b0;
            pend_auto_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            hold_q      <= hold_d;
            auto_q      <= auto_d;
            wd_q        <= wd_d;
            pend_btn_q  <= pend_btn_d;
            pend_uart_q <= pend_uart_d;
            pend_auto_q <= pend_auto_d;
        end
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            src_q   <= 2'b00;
            retry_q <= 2'b00;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                        retry_q <= 2'b00;
                        src_q   <= pend_btn_q ? 2'b01 : (pend_uart_q ? 2'b10 : 2'b11);
                    end
                end
                START: begin
                    start_q <= 1'b1;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (ok_ev) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (fail_ev) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_q <= retry_q + 1'b1;
                            state_q <= RETRY;
                        end else begin
                            fail_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                RETRY: begin
                    if (hold_q == '0 && !iDhtBusy) begin
                        state_q <= START;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign oDhtStart = start_q;
    assign oBusy     = busy_q;
    assign oMeasDone = done_q;
    assign oMeasFail = fail_q;
    assign oSrc      = src_q;
    assign oRetryCnt = retry_q;

`ifdef DHT_SCHED_STATS_EN
    logic [15:0] ok_cnt_q, fail_cnt_q;

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            ok_cnt_q   <= '0;
            fail_cnt_q <= '0;
        end else begin
            if (ok_ev && ok_cnt_q != 16'hFFFF) begin
                ok_cnt_q <= ok_cnt_q + 16'd1;
            end
            if (fail_ev && fail_cnt_q != 16'hFFFF) begin
                fail_cnt_q <= fail_cnt_q + 16'd1;
            end
        end
    end

    assign oOkCnt   = ok_cnt_q;
    assign oFailCnt = fail_cnt_q;
`endif

endmodule

// File: tb/tb_dht11_meas_scheduler.sv
// tb/tb_dht11_meas_scheduler.sv - directed bench for dht11_meas_scheduler
module tb_dht11_meas_scheduler;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic btn = 1'b0, uart = 1'b0, auto_en = 1'b0, dbusy = 1'b0, ddone = 1'b0, derr = 1'b0;
    logic start, busy, mdone, mfail;
    logic [1:0] src, rcnt;
`ifdef DHT_SCHED_STATS_EN
    logic [15:0] ok_cnt, fail_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dht11_meas_scheduler #(
        .CLK_PER_US(1), .MIN_INTERVAL_MS(2), .AUTO_PERIOD_MS(10),
        .WAIT_TIMEOUT_MS(3), .MAX_RETRY(2)
    ) dut (
        .iClk(clk), .iRstn(rstn), .iReqBtn(btn), .iReqUart(uart), .iAutoEn(auto_en),
        .iDhtBusy(dbusy), .iDhtDone(ddone), .iDhtErr(derr),
        .oDhtStart(start), .oBusy(busy), .oMeasDone(mdone), .oMeasFail(mfail),
        .oSrc(src), .oRetryCnt(rcnt)
`ifdef DHT_SCHED_STATS_EN
        , .oOkCnt(ok_cnt), .oFailCnt(fail_cnt)
`endif
    );

    // Response codes: 0 = done after 50 cycles, 1 = error after 10 cycles, 2 = silent
    typedef struct {
        logic       b;
        logic       u;
        logic [1:0] r0, r1, r2;
        logic [1:0] exp_src;
        logic [1:0] exp_rc;
        logic       exp_ok;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sig(input int sel, input int budget, output int cyc);
        bit hit;
        hit = 1'b0;
        cyc = 0;
        while (!hit && cyc < budget) begin
            step();
            cyc++;
            case (sel)
                0:       hit = start;
                1:       hit = mdone;
                default: hit = mfail;
            endcase
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL wait_%0d: timeout after %0d cycles", sel, budget);
            cyc = -1;
        end
    endtask

    task automatic idle_gap(input int n, input string name);
        int cnt;
        cnt = 0;
        repeat (n) begin
            step();
            if (start) cnt++;
        end
        check(name, cnt, 0);
    endtask

    initial begin
        vec_t v;
        int c, n, t, t1, t2;
        bit fin, got_ok;
        logic [1:0] r;

        vecs[0] = '{b:1'b1, u:1'b0, r0:2'd0, r1:2'd0, r2:2'd0, exp_src:2'b01, exp_rc:2'd0, exp_ok:1'b1};
        vecs[1] = '{b:1'b0, u:1'b1, r0:2'd1, r1:2'd0, r2:2'd0, exp_src:2'b10, exp_rc:2'd1, exp_ok:1'b1};
        vecs[2] = '{b:1'b1, u:1'b1, r0:2'd0, r1:2'd0, r2:2'd0, exp_src:2'b01, exp_rc:2'd0, exp_ok:1'b1};
        vecs[3] = '{b:1'b1, u:1'b0, r0:2'd2, r1:2'd2, r2:2'd2, exp_src:2'b01, exp_rc:2'd2, exp_ok:1'b0};
        vecs[4] = '{b:1'b0, u:1'b1, r0:2'd1, r1:2'd2, r2:2'd0, exp_src:2'b10, exp_rc:2'd2, exp_ok:1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {start, busy, mdone, mfail, src, rcnt}, 0);
        rstn = 1'b1;

        // First request after reset: no holdoff, start two edges after the sampling edge
        btn = 1'b1; step(); btn = 1'b0;
        wait_sig(0, 10, c);
        check("first_latency", c, 2);
        check("first_src", src, 2'b01);
        check("first_rcnt", rcnt, 0);
        repeat (49) step();
        ddone = 1'b1; step(); ddone = 1'b0;
        check("first_done", mdone, 1);
        step();
        check("first_done_width", mdone, 0);
        check("first_busy_after", busy, 0);

        // Second request 100 cycles after done waits out the holdoff
        repeat (98) step();
        btn = 1'b1; step(); btn = 1'b0;
        wait_sig(0, 3000, c);
        check_rng("holdoff_start_after_done", c + 100, 1000, 2003);
        repeat (49) step();
        ddone = 1'b1; step(); ddone = 1'b0;
        check("holdoff_meas_done", mdone, 1);

        // Table of single measurements with scripted controller responses
        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
            idle_gap(2100, "row_idle_no_start");
            btn = v.b; uart = v.u; step(); btn = 1'b0; uart = 1'b0;
            step();
            check("row_lat_n1", start, 0);
            check("row_busy", busy, 1);
            step();
            check("row_lat_n2", start, 1);
            step();
            check("row_start_width", start, 0);
            fin = 1'b0;
            got_ok = 1'b0;
            for (int a = 0; a < 3 && !fin; a++) begin
                r = (a == 0) ? v.r0 : ((a == 1) ? v.r1 : v.r2);
                if (r == 2'd0) begin
                    repeat (48) step();
                    ddone = 1'b1; step(); ddone = 1'b0;
                    check("row_done_pulse", mdone, 1);
                    check("row_no_fail", mfail, 0);
                    got_ok = mdone;
                    fin = 1'b1;
                    step();
                    check("row_done_width", mdone, 0);
                    check("row_idle_busy", busy, 0);
                end else if (r == 2'd1) begin
                    repeat (8) step();
                    derr = 1'b1; step(); derr = 1'b0;
                    if (a == 2) begin
                        check("row_err_fail", mfail, 1);
                        fin = 1'b1;
                    end else begin
                        wait_sig(0, 2500, c);
                        check_rng("row_err_holdoff", c, 1000, 2003);
                        step();
                    end
                end else begin
                    if (a == 2) begin
                        wait_sig(2, 3100, c);
                        check_rng("row_wd_fail", c, 2998, 3000);
                        check("row_fail_no_done", mdone, 0);
                        check("row_fail_busy", busy, 0);
                        fin = 1'b1;
                    end else begin
                        wait_sig(0, 6000, c);
                        check_rng("row_wd_retry", c, 4999, 5003);
                        step();
                    end
                end
            end
            check("row_outcome", got_ok, v.exp_ok);
            check("row_src", src, v.exp_src);
            check("row_rcnt", rcnt, v.exp_rc);
        end

        // Responses outside WAIT are ignored; busy controller defers the start
        idle_gap(2100, "pre_busy_idle");
        ddone = 1'b1; step(); ddone = 1'b0;
        check("done_outside_wait", mdone, 0);
        derr = 1'b1; step(); derr = 1'b0;
        check("err_outside_wait", mfail, 0);
        dbusy = 1'b1;
        btn = 1'b1; step(); btn = 1'b0;
        idle_gap(20, "busy_blocks_start");
        dbusy = 1'b0;
        step();
        check("busy_release_n1", start, 0);
        step();
        check("busy_release_n2", start, 1);
        repeat (49) step();
        ddone = 1'b1; step(); ddone = 1'b0;
        check("busy_meas_done", mdone, 1);

        // Auto requests, then reset in the middle of a WAIT
        idle_gap(2100, "pre_auto_idle");
        auto_en = 1'b1;
        n = 0; t = 0; t1 = 0; t2 = 0;
        while (n < 2 && t < 25000) begin
            step();
            t++;
            if (start) begin
                n++;
                if (n == 1) begin
                    t1 = t;
                    check("auto_src1", src, 2'b11);
                    ddone = 1'b1; step(); t++; ddone = 1'b0;
                    check("auto_done", mdone, 1);
                end else begin
                    t2 = t;
                    check("auto_src2", src, 2'b11);
                end
            end
        end
        check("auto_start_count", n, 2);
        check_rng("auto_t1", t1, 9000, 10010);
        check_rng("auto_t2", t2, 19000, 20200);
        repeat (10) step();
        check("auto_wait_busy", busy, 1);
        rstn = 1'b0;
        #1;
        check("reset_async_outputs", {start, busy, mdone, mfail, src, rcnt}, 0);
        auto_en = 1'b0;
        step();
        step();
        rstn = 1'b1;
        idle_gap(3000, "post_reset_no_start");
        check("post_reset_src", src, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dht11_meas_scheduler.md
Name: dht11_meas_scheduler

Overview:
- Sequences the DHT11 single-wire controller.
- Collects measurement requests from three sources: the physical button, a UART command, and a periodic auto timer. Issues one-cycle start pulses to the controller.
- Enforces the sensor's minimum re-trigger interval, watchdogs each measurement, and retries failed reads.
- Sits in Top between the button debouncer/UART command decoder and the DHT11 controller.

Parameters:
- CLK_PER_US, 100, clock cycles per microsecond. The 1 ms tick equals CLK_PER_US*1000 cycles.
- MIN_INTERVAL_MS, 2000, holdoff in ms after any completed attempt (success or failure) before the next start.
- AUTO_PERIOD_MS, 5000, auto-request period in ms.
- WAIT_TIMEOUT_MS, 30, watchdog in ms for iDone/iErr after a start.
- MAX_RETRY, 2, retries after the first failed attempt. Total attempts are MAX_RETRY+1.

Ports:
- iClk  in  1  system clock.
- iRstn  in  1  asynchronous active-low reset.
- iReqBtn  in  1  one-cycle button request pulse.
- iReqUart  in  1  one-cycle UART request pulse.
- iAutoEn  in  1  level; enables periodic auto requests.
- iDhtBusy  in  1  DHT11 controller not idle.
- iDhtDone  in  1  one-cycle pulse: valid frame, checksum OK.
- iDhtErr  in  1  one-cycle pulse: protocol timeout or checksum error.
- oDhtStart  out  1  one-cycle start pulse to the DHT11 controller.
- oBusy  out  1  high in START, WAIT, RETRY.
- oMeasDone  out  1  one-cycle pulse on a successful measurement.
- oMeasFail  out  1  one-cycle pulse when all attempts are exhausted.
- oSrc  out  2  source of the current/last measurement: 00 none, 01 btn, 10 uart, 11 auto.
- oRetryCnt  out  2  retries used in the current/last measurement.

Behaviour:
- Reset (async, iRstn=0):
  - State IDLE; all outputs 0.
  - Pending flags, holdoff, auto, watchdog and prescaler counters all 0.
  - The first request after reset starts with no holdoff.
- Request latching:
  - iReqBtn, iReqUart and the auto-timer expiry each set a sticky pending flag on the next edge, in any state.
  - Repeated pulses while a flag is pending merge into that flag.
- Auto timer:
  - Counts ms ticks while iAutoEn=1 and is held at 0 while iAutoEn=0.
  - On reaching AUTO_PERIOD_MS it sets auto-pending and restarts from 0.
- Holdoff counter:
  - Counts down in ms ticks and saturates at 0.
  - Loaded with MIN_INTERVAL_MS on every iDhtDone, iDhtErr or watchdog expiry.
- IDLE:
  - Moves to START when any flag is pending AND holdoff=0 AND iDhtBusy=0.
  - oSrc takes the highest-priority pending source (btn > uart > auto).
  - All pending flags clear on this transition; one measurement serves every request pending at that moment.
  - Requests arriving later re-pend and cause a new measurement.
  - oRetryCnt clears to 0.
- START:
  - oDhtStart=1 for exactly one cycle.
  - Prescaler and watchdog restart, so watchdog timing is exact.
  - Goes to WAIT.
  - Latency: a request pulse sampled at edge N (IDLE, holdoff 0, controller idle) gives oDhtStart high after edge N+2.
- WAIT:
  - iDhtErr (wins if simultaneous with iDhtDone) or watchdog reaching WAIT_TIMEOUT_MS counts as a failure.
  - iDhtDone alone: oMeasDone pulses, then IDLE.
  - Failure with oRetryCnt<MAX_RETRY: oRetryCnt+1, go to RETRY.
  - Failure otherwise: oMeasFail pulses, then IDLE.
- RETRY:
  - Waits for holdoff=0 and iDhtBusy=0, then goes to START.
  - oSrc is kept; pending flags are not consumed.
- iDhtDone/iDhtErr outside WAIT are ignored.
- oSrc and oRetryCnt hold their values after completion until the next IDLE→START.
- Counters use widths of clog2(param+1); no wrap is possible because every counter saturates or reloads.

Optional Feature:
- DHT_SCHED_STATS_EN defined:
  - Adds outputs oOkCnt[15:0] and oFailCnt[15:0].
  - oOkCnt increments on oMeasDone; oFailCnt increments on every failed attempt (including retried ones).
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and their logic are absent.

Test Plan (CLK_PER_US=1, MIN_INTERVAL_MS=2, AUTO_PERIOD_MS=10, WAIT_TIMEOUT_MS=3, MAX_RETRY=2):
- Reset, iReqBtn pulse at edge N, iDhtDone 50 cycles after the start → oDhtStart high after N+2; oMeasDone one cycle; oSrc=01; oRetryCnt=0; oBusy low after.
- Second iReqBtn 100 cycles after iDhtDone → oDhtStart 2000 cycles (±1 ms tick) after iDhtDone, not earlier.
- iReqUart and iReqBtn in the same cycle → a single oDhtStart, oSrc=01, no second start without a new request.
- Start, then model silent → watchdog fires at 3000 cycles; three starts total spaced by holdoff; then oMeasFail; oRetryCnt=2.
- iDhtErr on attempt 1, iDhtDone on attempt 2 → oMeasDone, oRetryCnt=1, no oMeasFail.
- iAutoEn=1 for 25 ms with immediate iDhtDone → starts at ~10 ms and ~20 ms with oSrc=11; iRstn low mid-WAIT → all outputs 0 immediately; no start after release without a request.
